// File: rtl/ifetch_queue.sv
// Instruction fetch stage: in-order word fetches into a small prefetch FIFO,
// a valid/ready handshake to decode, and redirects that flush the queue and
// drop any responses still in flight.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   fifo_word [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_aligned;
  logic          issue;
  logic          push;
  logic          pop;

  // Everything queued, in flight, or waiting to be dropped consumes a credit.
  assign credit_used      = {1'b0, count} + {1'b0, outstanding} + {1'b0, drop_cnt};
  assign redirect_aligned = redirect_pc & ~32'h0000_0003;

  assign req_valid   = reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign req_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = fifo_word[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  assign issue = req_valid && req_ready;
  assign push  = resp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop   = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_word[i] <= '0;
        fifo_pc[i]   <= RESET_PC;
      end
    end else if (redirect_valid) begin
      // A response arriving in the redirect cycle is itself one of the dropped ones.
      count       <= '0;
      rd_ptr      <= wr_ptr;
      fetch_pc    <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      drop_cnt    <= drop_cnt + outstanding - CW'(resp_valid);
      outstanding <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        fifo_word[wr_ptr] <= resp_data;
        fifo_pc[wr_ptr]   <= resp_pc;
        wr_ptr            <= wr_ptr + AW'(1);
        resp_pc           <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({issue, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a latency-programmable in-order memory
// model feeds the DUT and a scoreboard of expected PCs checks what decode sees.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          accepts = 0;
  int          test_deliv = 0;
  logic [31:0] first_pc = '0;
  logic [31:0] last_pc = '0;
  logic [31:0] nxt = RESET_PC;
  logic        rst_v = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;
  logic        rr = 1'b1;
  logic        ir = 1'b1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_1357;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then book-keep the
  // handshakes that the coming rising edge will commit.
  task automatic step();
    @(negedge clk);
    reset          = rst_v;
    redirect_valid = redir;
    redirect_pc    = rpc;
    req_ready      = rr;
    instr_ready    = ir;
    if (!rst_v) begin
      mq.delete();
      exp_q.delete();
      nxt        = RESET_PC;
      resp_valid = 1'b0;
      resp_data  = '0;
    end else if (mq.size() != 0 && mq[0].rdy <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
    #1;
    if (rst_v) begin
      if (instr_valid && ir && !redir) begin
        if (exp_q.size() == 0) begin
          check("instr_valid_unexpected", {31'b0, instr_valid}, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr_word", instr, word_of(e));
          if (test_deliv == 0) first_pc = instr_pc;
          last_pc = instr_pc;
          test_deliv++;
        end
      end
      if (redir) begin
        exp_q.delete();
        nxt = rpc & ~32'h3;
      end
      if (req_valid && rr) begin
        check("req_addr", req_addr, nxt);
        mq.push_back('{addr: req_addr, rdy: cyc + lat});
        exp_q.push_back(req_addr);
        nxt = nxt + 32'd4;
        accepts++;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    redir = 1'b0;
    run(2);
    rst_v      = 1'b1;
    accepts    = 0;
    test_deliv = 0;
  endtask

  initial begin
    reset = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_req_addr", req_addr, RESET_PC);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, RESET_PC);

    // Streaming with a 1-cycle memory.
    lat = 1; rr = 1'b1; ir = 1'b1;
    do_reset();
    step();
    check("first_req_valid", {31'b0, req_valid}, 32'd1);
    check("first_req_addr", req_addr, RESET_PC);
    run(11);
    check("stream_deliv", test_deliv, 32'd10);
    check("stream_last_pc", last_pc, 32'h24);

    // Decode stalled: exactly DEPTH fetches, then drain and resume at 0x10.
    ir = 1'b0;
    do_reset();
    run(8);
    check("stall_accepts", accepts, 32'd4);
    check("stall_req_valid", {31'b0, req_valid}, 32'd0);
    check("stall_instr_pc", instr_pc, 32'h0);
    ir = 1'b1;
    step();
    step();
    check("resume_req_valid", {31'b0, req_valid}, 32'd1);
    check("resume_req_addr", req_addr, 32'h10);
    run(10);
    check("resume_deliv", {31'b0, test_deliv >= 4}, 32'd1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    run(2);
    redir = 1'b1; rpc = 32'h100;
    step();
    check("redir_no_req", {31'b0, req_valid}, 32'd0);
    redir = 1'b0;
    step();
    check("redir_req_valid", {31'b0, req_valid}, 32'd1);
    check("redir_req_addr", req_addr, 32'h100);
    run(12);
    check("redir_deliv", {31'b0, test_deliv > 0}, 32'd1);
    check("redir_first_pc", first_pc, 32'h100);

    // Redirect coinciding with a response and a pop, two entries queued.
    lat = 1; ir = 1'b0;
    do_reset();
    run(3);
    redir = 1'b1; rpc = 32'h100; ir = 1'b1;
    step();
    check("coinc_pre_valid", {31'b0, instr_valid}, 32'd1);
    check("coinc_pre_pc", instr_pc, 32'h0);
    redir = 1'b0;
    step();
    check("coinc_flushed", {31'b0, instr_valid}, 32'd0);
    check("coinc_req_valid", {31'b0, req_valid}, 32'd1);
    check("coinc_req_addr", req_addr, 32'h100);
    run(6);
    check("coinc_first_pc", first_pc, 32'h100);

    // Misaligned redirect target and address wrap.
    redir = 1'b1; rpc = 32'h203;
    step();
    redir = 1'b0;
    step();
    check("align_req_addr", req_addr, 32'h200);
    redir = 1'b1; rpc = 32'hFFFF_FFFC;
    step();
    redir = 1'b0;
    step();
    check("wrap_top_addr", req_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_zero_addr", req_addr, 32'h0);
    run(6);

    // Asynchronous reset with entries queued and requests outstanding.
    lat = 2; ir = 1'b0;
    do_reset();
    run(4);
    @(posedge clk);
    #2;
    check("midrst_pre_valid", {31'b0, instr_valid}, 32'd1);
    reset = 1'b0;
    rst_v = 1'b0;
    #1;
    check("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_req_valid", {31'b0, req_valid}, 32'd0);
    check("midrst_instr_pc", instr_pc, RESET_PC);
    ir = 1'b1;
    do_reset();
    step();
    check("midrst_restart_valid", {31'b0, req_valid}, 32'd1);
    check("midrst_restart_addr", req_addr, RESET_PC);
    run(8);
    check("midrst_first_pc", first_pc, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
